popcount_sequencer: RTL and testbench

POPCOUNT_SEQUENCER -- requirements
Module: popcount_sequencer

---
 rtl/popcount_pkg.sv | 13 +
 rtl/ones_counter_3.sv | 13 +
 rtl/popcount_sequencer.sv | 108 ++++++++++
 tb/tb_popcount_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount sequencer: FSM state encodings and slice width.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int SLICE_W = 3;

endpackage

// File: rtl/ones_counter_3.sv
// Combinational 3-input ones counter (full adder): y0 is the sum bit, y1 the carry bit.
module ones_counter_3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y0,
    output logic y1
);

    assign y0 = a ^ b ^ c;
    assign y1 = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/popcount_sequencer.sv
// Sequential population counter that consumes the captured word three bits per cycle.
// Optional feature macro: POPCOUNT_PARITY_EN adds a parity output equal to count[0].
//
// state | meaning
// IDLE  | waiting for start; count holds the last result
// LOAD  | word captured, accumulator and slice counter initialised
// RUN   | one 3-bit slice counted and shifted out per cycle
// DONE  | one-cycle done pulse, count valid
module popcount_sequencer
    import popcount_pkg::*;
#(
    parameter int W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     clear,
    input  logic [W-1:0]             data_in,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(W+1)-1:0]   count
`ifdef POPCOUNT_PARITY_EN
    ,
    output logic                     parity
`endif
);

    localparam int CW     = $clog2(W + 1);
    localparam int SLICES = W / SLICE_W;

    state_t          state;
    logic [W-1:0]    sreg;
    logic [CW-1:0]   acc;
    logic [CW-1:0]   slice_cnt;
    logic [CW-1:0]   acc_next;
    logic            ones_sum;
    logic            ones_carry;

    ones_counter_3 u_ones (
        .a  (sreg[0]),
        .b  (sreg[1]),
        .c  (sreg[2]),
        .y0 (ones_sum),
        .y1 (ones_carry)
    );

    // Worst case sum is W, which always fits in CW bits, so no saturation.
    assign acc_next = acc + CW'({ones_carry, ones_sum});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            acc       <= '0;
            sreg      <= '0;
            slice_cnt <= '0;
        end else if (clear) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            acc       <= '0;
            sreg      <= '0;
            slice_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        sreg      <= data_in;
                        acc       <= '0;
                        slice_cnt <= CW'(SLICES);
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    acc       <= acc_next;
                    sreg      <= sreg >> SLICE_W;
                    slice_cnt <= slice_cnt - CW'(1);
                    // Last slice: publish the sum including this cycle's contribution.
                    if (slice_cnt == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        count <= acc_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef POPCOUNT_PARITY_EN
    assign parity = count[0];
`endif

endmodule

// File: tb/tb_popcount_sequencer.sv
// Directed self-checking bench for popcount_sequencer (W=12) with an expected-count scoreboard.
module tb_popcount_sequencer;

    localparam int W  = 12;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          clear;
    logic [W-1:0]  data_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
`ifdef POPCOUNT_PARITY_EN
    logic          parity;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    int exp_q[$];
    int mon_exp;

    always #5 clk = ~clk;

    popcount_sequencer #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .clear   (clear),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .count   (count)
`ifdef POPCOUNT_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expected count.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            n_done++;
            check("done_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("count", 32'(count), mon_exp);
`ifdef POPCOUNT_PARITY_EN
                check("parity", 32'(parity), 32'(mon_exp & 1));
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [W-1:0] d);
        int lat;
        int busy_n;
        exp_q.push_back($countones(d));
        start   = 1'b1;
        data_in = d;
        step(1);
        start   = 1'b0;
        data_in = W'($urandom);
        lat     = 1;
        busy_n  = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 20) begin
            step(1);
            lat++;
            if (busy === 1'b1) busy_n++;
        end
        check("latency", 32'(lat), 6);
        check("busy_cycles", 32'(busy_n), 5);
        step(1);
        check("done_single_pulse", 32'(done), 0);
    endtask

    initial begin
        int d0;
        rst_n   = 1'b0;
        start   = 1'b0;
        clear   = 1'b0;
        data_in = '0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);
        rst_n = 1'b1;
        step(3);
        check("idle_after_reset", 32'(busy), 0);

        run_op(12'hFFF);
        run_op(12'h000);
        run_op(12'hA5A);

        // A second start arriving mid-RUN must be ignored.
        d0 = n_done;
        exp_q.push_back(4);
        start   = 1'b1;
        data_in = 12'h00F;
        step(1);
        start = 1'b0;
        step(3);
        start   = 1'b1;
        data_in = 12'hFFF;
        step(1);
        start = 1'b0;
        step(10);
        check("busy_start_one_done", 32'(n_done - d0), 1);
        check("busy_start_idle", 32'(busy), 0);

        // Clear during RUN aborts without a done pulse.
        d0 = n_done;
        start   = 1'b1;
        data_in = 12'h0FF;
        step(1);
        start = 1'b0;
        step(2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_busy", 32'(busy), 0);
        check("clear_done", 32'(done), 0);
        check("clear_count", 32'(count), 0);
        step(8);
        check("clear_no_done", 32'(n_done - d0), 0);

        // Clear wins over start in IDLE.
        run_op(12'h0F0);
        d0 = n_done;
        clear   = 1'b1;
        start   = 1'b1;
        data_in = 12'hFFF;
        step(1);
        clear = 1'b0;
        start = 1'b0;
        check("clear_start_busy", 32'(busy), 0);
        check("clear_start_count", 32'(count), 0);
        step(8);
        check("clear_start_no_done", 32'(n_done - d0), 0);

        // Asynchronous reset mid-RUN.
        run_op(12'h0FF);
        d0 = n_done;
        start   = 1'b1;
        data_in = 12'h111;
        step(1);
        start = 1'b0;
        step(2);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_count", 32'(count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8);
        check("arst_no_done", 32'(n_done - d0), 0);
        check("arst_idle", 32'(busy), 0);
        run_op(12'h001);

        // Start held high re-triggers after each return to IDLE.
        d0 = n_done;
        exp_q.push_back(3);
        exp_q.push_back(3);
        start   = 1'b1;
        data_in = 12'h007;
        repeat (8) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        step(10);
        check("retrigger_dones", 32'(n_done - d0), 2);

        run_op(12'h007);
        run_op(12'h003);

        step(2);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
